axi_wr_arbiter: RTL and testbench

- Write-path arbiter for the 4-master AXI interconnect.
- Shares a single downstream AW/W/B channel set between masters 0..3 using round-robin priority.
- Holds one grant per transaction, from selection through the B-channel handshake, so AW, W and B are never interleaved between masters.
- Drives one-hot grant and an encoded index; the write-path muxes/demuxes use these to steer AW, W and B.

---
 rtl/axi_ic_pkg.sv | 28 ++
 rtl/axi_rr_pick4.sv | 42 ++++
 rtl/axi_wr_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_ic_pkg
// Purpose : Shared definitions for the 4-master AXI interconnect.
//           Provides the write-arbiter state encoding, the master count and
//           the master index encodings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package axi_ic_pkg;

  localparam int NUM_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    MST0 = 2'd0,
    MST1 = 2'd1,
    MST2 = 2'd2,
    MST3 = 2'd3
  } mst_idx_e;

endpackage : axi_ic_pkg
`default_nettype wire

// File: rtl/axi_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module  : axi_rr_pick4
// Purpose : Combinational 4-way round-robin picker. Returns the first set
//           request bit found searching from ptr_i upward (mod 4).
// Ports   : req_i   [3:0] request bits (bit i = master i)
//           ptr_i   [1:0] highest-priority position
//           gnt_o   [3:0] one-hot winner (zero when no request)
//           idx_o   [1:0] encoded winner (zero when no request)
//           valid_o       at least one request present
// Rev     : 1.0  initial release
// ============================================================================
module axi_rr_pick4
  import axi_ic_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [1:0]             ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [1:0]             idx_o,
  output logic                   valid_o
);

  logic [1:0] cand;

  // Walk from the lowest priority offset to the highest so that the
  // position at ptr_i overrides everything else when it is requesting.
  always_comb begin
    cand    = ptr_i;
    idx_o   = MST0;
    valid_o = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
    gnt_o = valid_o ? (4'b0001 << idx_o) : 4'b0000;
  end

endmodule : axi_rr_pick4
`default_nettype wire

// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_wr_arbiter
// Purpose : Round-robin write-path arbiter. Holds one grant from selection
//           through the B handshake so AW/W/B never interleave between
//           masters. Tracks AW and W completion independently and flags a
//           sticky length error when WLAST does not land on AWLEN+1.
// Ports   : ACLK, ARESETn (async, active-low)
//           m_awvalid[3:0]        per-master AWVALID
//           s_awvalid/s_awready/s_awlen  muxed AW handshake + length
//           s_wvalid/s_wready/s_wlast    muxed W handshake + last
//           s_bvalid/s_bready            B handshake
//           wgrnt[3:0], wgrnt_idx[1:0]   one-hot / encoded grant
//           busy                         not IDLE
//           len_err                      sticky burst-length mismatch
//           grant_cnt[63:0]              per-master grant counters
//                                        (only with AXI_WR_ARB_STATS_EN)
// Config  : `define AXI_WR_ARB_STATS_EN adds grant_cnt.
// Rev     : 1.0  initial release
// ============================================================================
module axi_wr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int BURST_CNT_W = 9
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_MASTERS-1:0] m_awvalid,
  input  logic                   s_awvalid,
  input  logic                   s_awready,
  input  logic [7:0]             s_awlen,
  input  logic                   s_wvalid,
  input  logic                   s_wready,
  input  logic                   s_wlast,
  input  logic                   s_bvalid,
  input  logic                   s_bready,
  output logic [NUM_MASTERS-1:0] wgrnt,
  output logic [1:0]             wgrnt_idx,
  output logic                   busy,
  output logic                   len_err
`ifdef AXI_WR_ARB_STATS_EN
  ,
  output logic [63:0]            grant_cnt
`endif
);

  wr_state_e              state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [1:0]             idx_q, idx_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [BURST_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BURST_CNT_W-1:0] exp_beats_q, exp_beats_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   len_err_q, len_err_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [1:0]             pick_idx;
  logic                   pick_valid;

  logic aw_hs, w_hs, b_hs;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  axi_rr_pick4 u_pick (
    .req_i   (m_awvalid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      idx_q       <= MST0;
      rr_ptr_q    <= MST0;
      beat_cnt_q  <= '0;
      exp_beats_q <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_beats_q <= exp_beats_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      len_err_q   <= len_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    exp_beats_d = exp_beats_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    len_err_d   = len_err_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        if (aw_hs && !aw_done_q) begin
          aw_done_d   = 1'b1;
          exp_beats_d = BURST_CNT_W'(s_awlen) + BURST_CNT_W'(1);
        end
        // Beats after WLAST do not belong to this burst and are not counted.
        if (w_hs && !w_done_q) begin
          if (beat_cnt_q != '1) begin
            beat_cnt_d = beat_cnt_q + BURST_CNT_W'(1);
          end
          if (s_wlast) begin
            w_done_d = 1'b1;
          end
        end
        // Using the next-state flags lets an AW and WLAST landing in the
        // same cycle (or in either order) move to RESP on the following
        // cycle; the length check is done once both are known.
        if (aw_done_d && w_done_d) begin
          state_d = RESP;
          if (beat_cnt_d != exp_beats_d) begin
            len_err_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          rr_ptr_d    = idx_q + 2'd1;
          gnt_d       = '0;
          beat_cnt_d  = '0;
          exp_beats_d = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign wgrnt     = gnt_q;
  assign wgrnt_idx = idx_q;
  assign busy      = (state_q != IDLE);
  assign len_err   = len_err_q;

`ifdef AXI_WR_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_MASTERS];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if ((state_q == IDLE) && pick_valid && (pick_idx == 2'(i)) &&
            (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_grant_cnt
    assign grant_cnt[16*g +: 16] = grant_cnt_q[g];
  end
`endif

endmodule : axi_wr_arbiter
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_wr_arbiter
// Purpose : Directed self-checking bench for axi_wr_arbiter. Inputs change
//           and outputs are sampled 1 ns after each rising clock edge.
// Rev     : 1.0  initial release
// ============================================================================
module tb_axi_wr_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [3:0] m_awvalid = '0;
  logic       s_awvalid = 1'b0, s_awready = 1'b0;
  logic [7:0] s_awlen = '0;
  logic       s_wvalid = 1'b0, s_wready = 1'b0, s_wlast = 1'b0;
  logic       s_bvalid = 1'b0, s_bready = 1'b0;
  logic [3:0] wgrnt;
  logic [1:0] wgrnt_idx;
  logic       busy, len_err;
`ifdef AXI_WR_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  axi_wr_arbiter #(.BURST_CNT_W(9)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .m_awvalid (m_awvalid),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awlen   (s_awlen),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wlast   (s_wlast),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .wgrnt     (wgrnt),
    .wgrnt_idx (wgrnt_idx),
    .busy      (busy),
    .len_err   (len_err)
`ifdef AXI_WR_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_aw(input logic [7:0] len);
    s_awvalid = 1'b1; s_awready = 1'b1; s_awlen = len;
    tick();
    s_awvalid = 1'b0; s_awready = 1'b0; s_awlen = '0;
  endtask

  task automatic do_w(input logic last);
    s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = last;
    tick();
    s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;
  endtask

  // Single-beat burst: AW (len 0) and the WLAST beat in the same cycle.
  task automatic do_aw_w1;
    s_awvalid = 1'b1; s_awready = 1'b1; s_awlen = 8'd0;
    s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = 1'b1;
    tick();
    s_awvalid = 1'b0; s_awready = 1'b0;
    s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic do_b;
    s_bvalid = 1'b1; s_bready = 1'b1;
    tick();
    s_bvalid = 1'b0; s_bready = 1'b0;
  endtask

  task automatic test_reset;
    tick(); tick();
    vecs++; if (wgrnt !== 4'b0000) begin errs++; $display("FAIL rst_wgrnt: got %b want %b", wgrnt, 4'b0000); end
    vecs++; if (wgrnt_idx !== 2'd0) begin errs++; $display("FAIL rst_idx: got %0d want %0d", wgrnt_idx, 0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want %b", busy, 1'b0); end
    vecs++; if (len_err !== 1'b0) begin errs++; $display("FAIL rst_len_err: got %b want %b", len_err, 1'b0); end
    ARESETn = 1'b1;
    m_awvalid = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++; if (wgrnt !== 4'b0000 || busy !== 1'b0) begin errs++; $display("FAIL idle_no_req[%0d]: got wgrnt=%b busy=%b want 0000/0", i, wgrnt, busy); end
    end
  endtask

  task automatic test_basic;
    m_awvalid = 4'b1010;
    tick();
    vecs++; if (wgrnt !== 4'b0010) begin errs++; $display("FAIL basic_grant: got %b want %b", wgrnt, 4'b0010); end
    vecs++; if (wgrnt_idx !== 2'd1) begin errs++; $display("FAIL basic_idx: got %0d want %0d", wgrnt_idx, 1); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy: got %b want %b", busy, 1'b1); end
    do_aw(8'd3);
    do_w(1'b0); do_w(1'b0); do_w(1'b0);
    vecs++; if (wgrnt !== 4'b0010) begin errs++; $display("FAIL basic_hold: got %b want %b", wgrnt, 4'b0010); end
    do_w(1'b1);
    do_b();
    m_awvalid = 4'b1000;
    vecs++; if (wgrnt !== 4'b0000 || busy !== 1'b0) begin errs++; $display("FAIL basic_release: got wgrnt=%b busy=%b want 0000/0", wgrnt, busy); end
    vecs++; if (len_err !== 1'b0) begin errs++; $display("FAIL basic_len_ok: got %b want %b", len_err, 1'b0); end
    tick();
    vecs++; if (wgrnt !== 4'b1000) begin errs++; $display("FAIL basic_next_grant: got %b want %b", wgrnt, 4'b1000); end
    vecs++; if (wgrnt_idx !== 2'd3) begin errs++; $display("FAIL basic_next_idx: got %0d want %0d", wgrnt_idx, 3); end
    // Dropping the granted master's request must not disturb the grant.
    m_awvalid = 4'b0000;
    tick();
    vecs++; if (wgrnt !== 4'b1000) begin errs++; $display("FAIL basic_drop_hold: got %b want %b", wgrnt, 4'b1000); end
    do_aw_w1();
    do_b();
    vecs++; if (wgrnt !== 4'b0000) begin errs++; $display("FAIL basic_same_cycle_done: got %b want %b", wgrnt, 4'b0000); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_idx [5];
    exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd2;
    exp_idx[3] = 2'd3; exp_idx[4] = 2'd0;
    m_awvalid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++; if (wgrnt !== (4'b0001 << exp_idx[i]) || wgrnt_idx !== exp_idx[i]) begin errs++; $display("FAIL rr_order[%0d]: got wgrnt=%b idx=%0d want idx=%0d", i, wgrnt, wgrnt_idx, exp_idx[i]); end
      do_aw_w1();
      do_b();
    end
    m_awvalid = 4'b0000;
  endtask

  task automatic test_w_before_aw;
    m_awvalid = 4'b0001;
    tick();
    vecs++; if (wgrnt !== 4'b0001) begin errs++; $display("FAIL wfirst_grant: got %b want %b", wgrnt, 4'b0001); end
    m_awvalid = 4'b0000;
    do_w(1'b0);
    do_w(1'b1);
    // AW not yet seen: a B handshake now must be ignored.
    do_b();
    vecs++; if (wgrnt !== 4'b0001 || busy !== 1'b1) begin errs++; $display("FAIL wfirst_b_ignored: got wgrnt=%b busy=%b want 0001/1", wgrnt, busy); end
    do_aw(8'd1);
    do_b();
    vecs++; if (wgrnt !== 4'b0000 || busy !== 1'b0) begin errs++; $display("FAIL wfirst_resp: got wgrnt=%b busy=%b want 0000/0", wgrnt, busy); end
    vecs++; if (len_err !== 1'b0) begin errs++; $display("FAIL wfirst_len_ok: got %b want %b", len_err, 1'b0); end
  endtask

  task automatic test_len_err;
    m_awvalid = 4'b0100;
    tick();
    vecs++; if (wgrnt !== 4'b0100) begin errs++; $display("FAIL lerr_grant: got %b want %b", wgrnt, 4'b0100); end
    m_awvalid = 4'b0000;
    do_aw(8'd3);
    do_w(1'b0);
    do_w(1'b1);
    do_b();
    vecs++; if (len_err !== 1'b1) begin errs++; $display("FAIL lerr_set: got %b want %b", len_err, 1'b1); end
    vecs++; if (wgrnt !== 4'b0000) begin errs++; $display("FAIL lerr_release: got %b want %b", wgrnt, 4'b0000); end
    // rr_ptr is now 3: master 1 alone must still win.
    m_awvalid = 4'b0010;
    tick();
    vecs++; if (wgrnt !== 4'b0010) begin errs++; $display("FAIL lerr_next_grant: got %b want %b", wgrnt, 4'b0010); end
    m_awvalid = 4'b0000;
    do_aw_w1();
    do_b();
    vecs++; if (len_err !== 1'b1) begin errs++; $display("FAIL lerr_sticky: got %b want %b", len_err, 1'b1); end
  endtask

  task automatic test_reset_mid;
    m_awvalid = 4'b1000;
    tick();
    vecs++; if (wgrnt !== 4'b1000) begin errs++; $display("FAIL rmid_grant: got %b want %b", wgrnt, 4'b1000); end
    m_awvalid = 4'b0000;
    do_aw(8'd0);
    ARESETn = 1'b0;
    #1;
    vecs++; if (wgrnt !== 4'b0000 || busy !== 1'b0) begin errs++; $display("FAIL rmid_async: got wgrnt=%b busy=%b want 0000/0", wgrnt, busy); end
    vecs++; if (len_err !== 1'b0) begin errs++; $display("FAIL rmid_len_err_clr: got %b want %b", len_err, 1'b0); end
    tick(); tick();
    ARESETn = 1'b1;
    m_awvalid = 4'b0100;
    tick();
    vecs++; if (wgrnt !== 4'b0100 || wgrnt_idx !== 2'd2) begin errs++; $display("FAIL rmid_regrant: got wgrnt=%b idx=%0d want 0100/2", wgrnt, wgrnt_idx); end
    m_awvalid = 4'b0000;
    do_aw_w1();
    do_b();
    // rr_ptr is now 3; a reset must bring it back to 0 so master 0 beats master 3.
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    m_awvalid = 4'b1001;
    tick();
    vecs++; if (wgrnt !== 4'b0001 || wgrnt_idx !== 2'd0) begin errs++; $display("FAIL rmid_ptr_restart: got wgrnt=%b idx=%0d want 0001/0", wgrnt, wgrnt_idx); end
    m_awvalid = 4'b0000;
    do_aw_w1();
    do_b();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_w_before_aw();
    test_len_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_axi_wr_arbiter
`default_nettype wire
